decode_pipe: RTL and testbench
==============================

DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning decoded-record queue depth (power of two, >=2).
REQ-002 SHALL have parameter PC_WIDTH, default 32, meaning width of pc_in/pc_out.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  fetch offers insn/pc.
REQ-006 SHALL have port in_ready  output  1  block accepts this cycle.
REQ-007 SHALL have port insn  input  32  MIPS instruction word.
REQ-008 SHALL have port pc_in  input  PC_WIDTH  pc of insn.
REQ-009 SHALL have port flush  input  1  discard all queued records.
REQ-010 SHALL have port out_valid  output  1  head record valid.
REQ-011 SHALL have port out_ready  input  1  execute consumes head.
REQ-012 SHALL have port opcode_out, rs_out, rt_out, rd_out, sa_out, func_out  output  6/5/5/5/5/6  raw fields of head record.
REQ-013 SHALL have port imm_out  output  32  extended immediate.
REQ-014 SHALL have port target_out  output  26  J-type target.
REQ-015 SHALL have port pc_out  output  PC_WIDTH  pc of head.
REQ-016 SHALL have port class_out  output  2  0=R, 1=I, 2=J, 3=illegal.
REQ-017 SHALL have port wr_en_out, wr_reg_out  output  1/5  register write enable and destination.
REQ-018 SHALL have port illegal_out  output  1  unsupported encoding.

Function
REQ-019 SHALL decode combinationally on insn, then push a record on the posedge where in_valid && in_ready.
REQ-020 SHALL drive in_ready = (count < DEPTH); no same-cycle pass-through when full.
REQ-021 SHALL present the oldest record on outputs; pop on posedge where out_valid && out_ready.
REQ-022 SHALL make a record pushed into an empty queue visible on out_valid one cycle later (latency 1).
REQ-023 SHALL leave count unchanged on simultaneous push and pop at any fill level, including full only if in_ready was high.
REQ-024 SHALL wrap read/write pointers modulo DEPTH.
REQ-025 SHALL on flush zero count and pointers and drop any same-cycle push; flush has priority over push and pop.
REQ-026 SHALL support R-type funct: ADD ADDU SUB SUBU MULT MULTU DIV DIVU MFHI MFLO SLT SLTU SLL SLLV SRL SRLV SRA SRAV AND OR XOR NOR JALR JR.
REQ-027 SHALL support opcodes: ADDI ADDIU SLTI SLTIU ORI XORI LUI(0x0F) LW SW LB SB LBU BEQ BNE BLEZ BGTZ REGIMM(0x01), J(0x02), JAL(0x03).
REQ-028 SHALL zero-extend imm for ORI/XORI, produce {imm,16'h0} for LUI, sign-extend for all other I-type, and output 0 for R/J.
REQ-029 SHALL set wr_reg_out = rd for R-type writers, rt for I-type ALU/load, 31 for JAL; wr_en_out = 0 for MULT MULTU DIV DIVU JR, stores, branches, J.
REQ-030 SHALL force wr_en_out = 0 whenever the destination is register 0 (insn 0x00000000 decodes as NOP, class R).

Reset
REQ-031 SHALL on reset_n low at posedge clear count, pointers, out_valid; all record outputs read 0 while queue empty.
REQ-032 SHALL discard in-flight records on reset mid-operation and hold in_ready low during reset.

Configuration
REQ-033 SHALL, with DECODE_PIPE_ILLEGAL_TRAP_EN defined, flag unsupported opcode/funct with illegal_out=1, class_out=3, wr_en_out=0.
REQ-034 SHALL, without DECODE_PIPE_ILLEGAL_TRAP_EN, tie illegal_out=0 and decode unsupported encodings as class R, wr_en_out=0.

Structure
REQ-035 SHALL place opcode/funct constants, class encodings and the decoded-record struct typedef in shared package mips_pkg.
REQ-036 SHALL implement the combinational decoder as sub-module decode_fields; the queue stays in decode_pipe.

Verification
REQ-037 SHALL cover: 0x2408FFFF (ADDIU) -> opcode 0x09, rt 8, imm 0xFFFFFFFF, wr_en 1, wr_reg 8, out_valid next cycle.
REQ-038 SHALL cover: 0x3408FFFF (ORI) -> imm 0x0000FFFF; 0x3C081234 (LUI) -> imm 0x12340000.
REQ-039 SHALL cover: 0x0C100000 (JAL) -> class 2, target 0x0100000, wr_reg 31, wr_en 1.
REQ-040 SHALL cover: DEPTH=4, out_ready=0, 5 offers -> in_ready low after 4 accepts; then out_ready=1 drains in order.
REQ-041 SHALL cover: flush with queue 2 full and in_valid high -> out_valid 0 next cycle, new insn not stored.
REQ-042 SHALL cover: 0xFC000000 with macro -> illegal 1, class 3; without macro -> illegal 0, wr_en 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode/funct constants, class encodings, decoded-record layout.
package mips_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  localparam logic [4:0] LINK_REG = 5'd31;

  typedef enum logic [1:0] {
    CLS_R   = 2'd0,
    CLS_I   = 2'd1,
    CLS_J   = 2'd2,
    CLS_ILL = 2'd3
  } insn_class_t;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [5:0]  func;
    logic [31:0] imm;
    logic [25:0] target;
    insn_class_t cls;
    logic        wr_en;
    logic [4:0]  wr_reg;
    logic        illegal;
  } dec_rec_t;

  localparam int DEC_REC_W = $bits(dec_rec_t);

endpackage

// File: rtl/decode_fields.sv
// Combinational MIPS field decoder; zero latency, no flow control.
// Unsupported encodings trap as class 3 only when DECODE_PIPE_ILLEGAL_TRAP_EN is defined.
module decode_fields
  import mips_pkg::*;
(
  input  logic [31:0]          insn,
  output logic [DEC_REC_W-1:0] rec_dat
);

  dec_rec_t    rec;
  logic        legal;
  logic        writes;
  logic [4:0]  dst;
  logic [31:0] sext;
  logic [31:0] zext;

  assign sext = {{16{insn[15]}}, insn[15:0]};
  assign zext = {16'h0000, insn[15:0]};

  always_comb begin
    rec        = '0;
    legal      = 1'b1;
    writes     = 1'b0;
    dst        = 5'd0;
    rec.opcode = insn[31:26];
    rec.rs     = insn[25:21];
    rec.rt     = insn[20:16];
    rec.rd     = insn[15:11];
    rec.sa     = insn[10:6];
    rec.func   = insn[5:0];
    rec.cls    = CLS_R;

    case (insn[31:26])
      OP_SPECIAL: begin
        case (insn[5:0])
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_MFHI, FN_MFLO,
          FN_SLT, FN_SLTU, FN_SLL, FN_SLLV, FN_SRL, FN_SRLV,
          FN_SRA, FN_SRAV, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_JALR: begin
            writes = 1'b1;
            dst    = insn[15:11];
          end
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_JR: writes = 1'b0;
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW, OP_LB, OP_LBU: begin
        rec.cls = CLS_I;
        rec.imm = sext;
        writes  = 1'b1;
        dst     = insn[20:16];
      end
      OP_ORI, OP_XORI: begin
        rec.cls = CLS_I;
        rec.imm = zext;
        writes  = 1'b1;
        dst     = insn[20:16];
      end
      OP_LUI: begin
        rec.cls = CLS_I;
        rec.imm = {insn[15:0], 16'h0000};
        writes  = 1'b1;
        dst     = insn[20:16];
      end
      // Stores and branches carry an offset but never write the register file.
      OP_SW, OP_SB, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM: begin
        rec.cls = CLS_I;
        rec.imm = sext;
      end
      OP_J: begin
        rec.cls    = CLS_J;
        rec.target = insn[25:0];
      end
      OP_JAL: begin
        rec.cls    = CLS_J;
        rec.target = insn[25:0];
        writes     = 1'b1;
        dst        = LINK_REG;
      end
      default: legal = 1'b0;
    endcase

`ifdef DECODE_PIPE_ILLEGAL_TRAP_EN
    rec.cls     = legal ? rec.cls : CLS_ILL;
    rec.illegal = ~legal;
`else
    rec.cls     = legal ? rec.cls : CLS_R;
    rec.illegal = 1'b0;
`endif

    // Writes to $zero are architecturally discarded.
    rec.wr_en  = writes && (dst != 5'd0);
    rec.wr_reg = writes ? dst : 5'd0;
  end

  assign rec_dat = rec;

endmodule

// File: rtl/decode_pipe.sv
// Decode stage: MIPS decoder feeding a DEPTH-entry record queue; push-to-visible latency 1 cycle.
// in_ready drops when full (no pass-through); flush empties the queue. Option: DECODE_PIPE_ILLEGAL_TRAP_EN.
module decode_pipe
  import mips_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int PC_WIDTH = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         insn,
  input  logic [PC_WIDTH-1:0] pc_in,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [5:0]          opcode_out,
  output logic [4:0]          rs_out,
  output logic [4:0]          rt_out,
  output logic [4:0]          rd_out,
  output logic [4:0]          sa_out,
  output logic [5:0]          func_out,
  output logic [31:0]         imm_out,
  output logic [25:0]         target_out,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic [1:0]          class_out,
  output logic                wr_en_out,
  output logic [4:0]          wr_reg_out,
  output logic                illegal_out
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DEC_REC_W-1:0] dec_dat;
  dec_rec_t             dec_rec;
  dec_rec_t             rec_mem [DEPTH];
  logic [PC_WIDTH-1:0]  pc_mem  [DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic                 push;
  logic                 pop;
  dec_rec_t             head;
  logic [PC_WIDTH-1:0]  head_pc;

  decode_fields u_decode_fields (
    .insn    (insn),
    .rec_dat (dec_dat)
  );

  assign dec_rec = dec_rec_t'(dec_dat);

  assign in_ready  = reset_n && (count < DEPTH_C);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed through out_valid.
  always_ff @(posedge clock) begin
    if (push && !flush) begin
      rec_mem[wr_ptr] <= dec_rec;
      pc_mem[wr_ptr]  <= pc_in;
    end
  end

  assign head    = out_valid ? rec_mem[rd_ptr] : '0;
  assign head_pc = out_valid ? pc_mem[rd_ptr]  : '0;

  assign opcode_out  = head.opcode;
  assign rs_out      = head.rs;
  assign rt_out      = head.rt;
  assign rd_out      = head.rd;
  assign sa_out      = head.sa;
  assign func_out    = head.func;
  assign imm_out     = head.imm;
  assign target_out  = head.target;
  assign pc_out      = head_pc;
  assign class_out   = head.cls;
  assign wr_en_out   = head.wr_en;
  assign wr_reg_out  = head.wr_reg;
  assign illegal_out = head.illegal;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed self-checking bench for decode_pipe (DEPTH=4).
module tb_decode_pipe;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] insn;
  logic [31:0] pc_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  opcode_out;
  logic [4:0]  rs_out;
  logic [4:0]  rt_out;
  logic [4:0]  rd_out;
  logic [4:0]  sa_out;
  logic [5:0]  func_out;
  logic [31:0] imm_out;
  logic [25:0] target_out;
  logic [31:0] pc_out;
  logic [1:0]  class_out;
  logic        wr_en_out;
  logic [4:0]  wr_reg_out;
  logic        illegal_out;

  int checks;
  int failures;

  decode_pipe #(.DEPTH(4), .PC_WIDTH(32)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .insn        (insn),
    .pc_in       (pc_in),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .opcode_out  (opcode_out),
    .rs_out      (rs_out),
    .rt_out      (rt_out),
    .rd_out      (rd_out),
    .sa_out      (sa_out),
    .func_out    (func_out),
    .imm_out     (imm_out),
    .target_out  (target_out),
    .pc_out      (pc_out),
    .class_out   (class_out),
    .wr_en_out   (wr_en_out),
    .wr_reg_out  (wr_reg_out),
    .illegal_out (illegal_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_one(input logic [31:0] i, input logic [31:0] p);
    in_valid = 1'b1;
    insn     = i;
    pc_in    = p;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    in_valid = 1'b1;
    insn     = 32'h2408FFFF;
    repeat (2) tick();
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if ({opcode_out, imm_out, pc_out, wr_en_out} !== 71'h0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", {opcode_out, imm_out, pc_out, wr_en_out});
    end
    in_valid = 1'b0;
    reset_n  = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", in_ready); end
    tick();
  endtask

  task automatic test_addiu();
    in_valid = 1'b1;
    insn     = 32'h2408FFFF;
    pc_in    = 32'h00000100;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL addiu_pre_valid got=%b exp=0", out_valid); end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL addiu_latency got=%b exp=1", out_valid); end
    checks++;
    if ({opcode_out, rt_out, imm_out} !== {6'h09, 5'd8, 32'hFFFFFFFF}) begin
      failures++; $display("FAIL addiu_fields got=%h exp=%h", {opcode_out, rt_out, imm_out}, {6'h09, 5'd8, 32'hFFFFFFFF});
    end
    checks++;
    if ({class_out, wr_en_out, wr_reg_out, illegal_out, pc_out} !== {2'd1, 1'b1, 5'd8, 1'b0, 32'h100}) begin
      failures++; $display("FAIL addiu_ctrl got=%h exp=%h", {class_out, wr_en_out, wr_reg_out, illegal_out, pc_out},
                           {2'd1, 1'b1, 5'd8, 1'b0, 32'h100});
    end
    pop_one();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL addiu_pop got=%b exp=0", out_valid); end
  endtask

  task automatic test_imm();
    push_one(32'h3408FFFF, 32'h104);
    checks++;
    if ({imm_out, wr_reg_out, class_out} !== {32'h0000FFFF, 5'd8, 2'd1}) begin
      failures++; $display("FAIL ori_imm got=%h exp=%h", {imm_out, wr_reg_out, class_out}, {32'h0000FFFF, 5'd8, 2'd1});
    end
    pop_one();
    push_one(32'h3C081234, 32'h108);
    checks++;
    if ({imm_out, wr_en_out} !== {32'h12340000, 1'b1}) begin
      failures++; $display("FAIL lui_imm got=%h exp=%h", {imm_out, wr_en_out}, {32'h12340000, 1'b1});
    end
    pop_one();
    push_one(32'hAD090004, 32'h10C);
    checks++;
    if ({imm_out, wr_en_out, class_out} !== {32'h00000004, 1'b0, 2'd1}) begin
      failures++; $display("FAIL sw_decode got=%h exp=%h", {imm_out, wr_en_out, class_out}, {32'h00000004, 1'b0, 2'd1});
    end
    pop_one();
    push_one(32'h01095020, 32'h110);
    checks++;
    if ({rs_out, rt_out, rd_out, func_out, wr_en_out, wr_reg_out, class_out, imm_out} !==
        {5'd8, 5'd9, 5'd10, 6'h20, 1'b1, 5'd10, 2'd0, 32'h0}) begin
      failures++; $display("FAIL add_decode got=%h exp=%h",
                           {rs_out, rt_out, rd_out, func_out, wr_en_out, wr_reg_out, class_out, imm_out},
                           {5'd8, 5'd9, 5'd10, 6'h20, 1'b1, 5'd10, 2'd0, 32'h0});
    end
    pop_one();
    push_one(32'h00000000, 32'h114);
    checks++;
    if ({out_valid, class_out, wr_en_out, illegal_out} !== {1'b1, 2'd0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL nop_decode got=%h exp=%h", {out_valid, class_out, wr_en_out, illegal_out}, 5'b10000);
    end
    pop_one();
  endtask

  task automatic test_jal();
    push_one(32'h0C100000, 32'h120);
    checks++;
    if ({class_out, target_out, wr_reg_out, wr_en_out, imm_out} !== {2'd2, 26'h0100000, 5'd31, 1'b1, 32'h0}) begin
      failures++; $display("FAIL jal_decode got=%h exp=%h", {class_out, target_out, wr_reg_out, wr_en_out, imm_out},
                           {2'd2, 26'h0100000, 5'd31, 1'b1, 32'h0});
    end
    pop_one();
  endtask

  task automatic test_full_drain();
    logic exp_rdy;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      insn     = 32'h24080000 | 32'(i);
      pc_in    = 32'h200 + 32'(4 * i);
      exp_rdy  = (i < 4);
      #1;
      checks++;
      if (in_ready !== exp_rdy) begin failures++; $display("FAIL full_in_ready[%0d] got=%b exp=%b", i, in_ready, exp_rdy); end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({out_valid, pc_out, imm_out} !== {1'b1, 32'h200 + 32'(4 * i), 32'(i)}) begin
        failures++; $display("FAIL drain_order[%0d] got=%h exp=%h", i, {out_valid, pc_out, imm_out},
                             {1'b1, 32'h200 + 32'(4 * i), 32'(i)});
      end
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      insn     = 32'h24090000 | 32'(i + 7);
      pc_in    = 32'h400 + 32'(4 * i);
      tick();
      checks++;
      if ({out_valid, pc_out, rt_out} !== {1'b1, 32'h400 + 32'(4 * i), 5'd9}) begin
        failures++; $display("FAIL b2b_head[%0d] got=%h exp=%h", i, {out_valid, pc_out, rt_out},
                             {1'b1, 32'h400 + 32'(4 * i), 5'd9});
      end
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    push_one(32'h2408000A, 32'h300);
    push_one(32'h2408000B, 32'h304);
    flush    = 1'b1;
    in_valid = 1'b1;
    insn     = 32'h2408000C;
    pc_in    = 32'h3F0;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin failures++; $display("FAIL flush_empty got=%b exp=01", {out_valid, in_ready}); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_store got=%b exp=0", out_valid); end
    push_one(32'h2408000D, 32'h310);
    checks++;
    if ({out_valid, pc_out, imm_out} !== {1'b1, 32'h310, 32'h0000000D}) begin
      failures++; $display("FAIL flush_reuse got=%h exp=%h", {out_valid, pc_out, imm_out}, {1'b1, 32'h310, 32'h0000000D});
    end
    pop_one();
  endtask

  task automatic test_illegal();
    push_one(32'hFC000000, 32'h500);
`ifdef DECODE_PIPE_ILLEGAL_TRAP_EN
    checks++;
    if ({illegal_out, class_out, wr_en_out} !== {1'b1, 2'd3, 1'b0}) begin
      failures++; $display("FAIL illegal_trap got=%b exp=%b", {illegal_out, class_out, wr_en_out}, 4'b1110);
    end
`else
    checks++;
    if ({illegal_out, class_out, wr_en_out} !== {1'b0, 2'd0, 1'b0}) begin
      failures++; $display("FAIL illegal_quiet got=%b exp=%b", {illegal_out, class_out, wr_en_out}, 4'b0000);
    end
`endif
    pop_one();
  endtask

  task automatic test_reset_mid();
    push_one(32'h24080001, 32'h600);
    push_one(32'h24080002, 32'h604);
    reset_n  = 1'b0;
    in_valid = 1'b1;
    insn     = 32'h24080003;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL midreset_ready got=%b exp=0", in_ready); end
    tick();
    reset_n  = 1'b1;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, pc_out} !== {1'b0, 32'h0}) begin failures++; $display("FAIL midreset_empty got=%h exp=0", {out_valid, pc_out}); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_stay got=%b exp=0", out_valid); end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    insn      = 32'h0;
    pc_in     = 32'h0;
    flush     = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_addiu();
    test_imm();
    test_jal();
    test_full_drain();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
